// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath selects.
module cpu_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010, ALU_SLT = 3'b011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  logic       pc_we_c, ir_we_c, iord_c, mem_we_c, reg_we_c, alu_src_a_c;
  logic       done_c, halted_c;
  logic [1:0] reg_dst_c, mem_to_reg_c, alu_src_b_c, pc_src_c;
  logic [2:0] alu_op_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (done_c) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = S_HALT;
    pc_we_c      = 1'b0;
    ir_we_c      = 1'b0;
    iord_c       = 1'b0;
    mem_we_c     = 1'b0;
    reg_we_c     = 1'b0;
    reg_dst_c    = 2'b00;
    mem_to_reg_c = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = ALU_ADD;
    pc_src_c     = 2'b00;
    done_c       = 1'b0;
    halted_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we_c     = 1'b1;
        pc_we_c     = 1'b1;
        alu_src_b_c = 2'b01;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) state_d = S_EXEC_R;
            else if (funct == FN_JR)                                   state_d = S_JUMP;
            else                                                       state_d = S_HALT;
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J, OP_JAL:     state_d = S_JUMP;
          default:          state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        if (funct == FN_SUB)      alu_op_c = ALU_SUB;
        else if (funct == FN_SLT) alu_op_c = ALU_SLT;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we_c  = 1'b1;
        reg_dst_c = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
        done_c    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord_c  = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we_c     = 1'b1;
        mem_to_reg_c = 2'b01;
        done_c       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        iord_c   = 1'b1;
        mem_we_c = 1'b1;
        done_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_SUB;
        pc_src_c    = 2'b01;
        pc_we_c     = (opcode == OP_BNE) ? ~zero : zero;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_we_c = 1'b1;
        pc_src_c = (opcode == OP_RTYPE) ? 2'b11 : 2'b10;
        if (opcode == OP_JAL) begin
          reg_we_c     = 1'b1;
          reg_dst_c    = 2'b10;
          mem_to_reg_c = 2'b10;
        end
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Reset masks every output so an abandoned instruction can never write.
  assign pc_we      = reset_n & pc_we_c;
  assign ir_we      = reset_n & ir_we_c;
  assign iord       = reset_n & iord_c;
  assign mem_we     = reset_n & mem_we_c;
  assign reg_we     = reset_n & reg_we_c;
  assign alu_src_a  = reset_n & alu_src_a_c;
  assign instr_done = reset_n & done_c;
  assign halted     = reset_n & halted_c;
  assign reg_dst    = reset_n ? reg_dst_c    : 2'b00;
  assign mem_to_reg = reset_n ? mem_to_reg_c : 2'b00;
  assign alu_src_b  = reset_n ? alu_src_b_c  : 2'b00;
  assign alu_op     = reset_n ? alu_op_c     : 3'b000;
  assign pc_src     = reset_n ? pc_src_c     : 2'b00;
  assign state      = reset_n ? state_q      : 4'd0;
  assign retired    = reset_n ? retired_q    : '0;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Directed bench for cpu_multicycle_ctrl: walks each instruction class through
// its state sequence and checks the control outputs against hand-derived values.
module tb_cpu_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        pc_we, ir_we, iord, mem_we, reg_we, alu_src_a, instr_done, halted;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  int pass_cnt = 0;
  int total    = 0;

  cpu_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_we(mem_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    #1;
    chk("rst_pc_we_t0", {31'd0, pc_we}, 0);
    chk("rst_ir_we_t0", {31'd0, ir_we}, 0);
    tick(); tick();
    chk("rst_state", {28'd0, state}, 0);
    chk("rst_retired", retired, 0);
    chk("rst_alu_src_b", {30'd0, alu_src_b}, 0);
    reset_n = 1'b1;
    #1;
    // FETCH after release
    chk("fetch_state", {28'd0, state}, 0);
    chk("fetch_ir_we", {31'd0, ir_we}, 1);
    chk("fetch_pc_we", {31'd0, pc_we}, 1);
    chk("fetch_alu_src_b", {30'd0, alu_src_b}, 1);
    chk("fetch_iord", {31'd0, iord}, 0);
    // R-type ADD
    opcode = 6'h00; funct = 6'h20;
    tick(); chk("add_s1", {28'd0, state}, 1);
    chk("dec_alu_src_b", {30'd0, alu_src_b}, 3);
    chk("dec_ir_we", {31'd0, ir_we}, 0);
    tick(); chk("add_s2", {28'd0, state}, 2);
    chk("add_src_a", {31'd0, alu_src_a}, 1);
    chk("add_alu_op", {29'd0, alu_op}, 0);
    tick(); chk("add_s8", {28'd0, state}, 8);
    chk("add_reg_we", {31'd0, reg_we}, 1);
    chk("add_reg_dst", {30'd0, reg_dst}, 1);
    chk("add_done", {31'd0, instr_done}, 1);
    chk("add_ret_before", retired, 0);
    tick(); chk("add_s0", {28'd0, state}, 0);
    chk("add_ret_after", retired, 1);
    // LW
    opcode = 6'h23;
    tick(); chk("lw_s1", {28'd0, state}, 1);
    tick(); chk("lw_s4", {28'd0, state}, 4);
    chk("lw_src_b", {30'd0, alu_src_b}, 2);
    tick(); chk("lw_s5", {28'd0, state}, 5);
    chk("lw_iord", {31'd0, iord}, 1);
    tick(); chk("lw_s6", {28'd0, state}, 6);
    chk("lw_m2r", {30'd0, mem_to_reg}, 1);
    chk("lw_reg_we", {31'd0, reg_we}, 1);
    chk("lw_reg_dst", {30'd0, reg_dst}, 0);
    tick(); chk("lw_s0", {28'd0, state}, 0);
    chk("lw_ret", retired, 2);
    // SW
    opcode = 6'h2B;
    tick(); chk("sw_s1", {28'd0, state}, 1);
    tick(); chk("sw_s4", {28'd0, state}, 4);
    chk("sw_mem_we_s4", {31'd0, mem_we}, 0);
    tick(); chk("sw_s7", {28'd0, state}, 7);
    chk("sw_mem_we", {31'd0, mem_we}, 1);
    chk("sw_reg_we", {31'd0, reg_we}, 0);
    chk("sw_iord", {31'd0, iord}, 1);
    tick(); chk("sw_s0", {28'd0, state}, 0);
    chk("sw_mem_we_s0", {31'd0, mem_we}, 0);
    chk("sw_ret", retired, 3);
    // BEQ taken
    opcode = 6'h04; zero = 1'b1;
    tick(); chk("beq_s1", {28'd0, state}, 1);
    tick(); chk("beq_s9", {28'd0, state}, 9);
    chk("beq_pc_we", {31'd0, pc_we}, 1);
    chk("beq_pc_src", {30'd0, pc_src}, 1);
    chk("beq_alu_op", {29'd0, alu_op}, 1);
    tick(); chk("beq_s0", {28'd0, state}, 0);
    chk("beq_ret", retired, 4);
    // BNE: zero=1 not taken, then zero=0 taken in the same cycle
    opcode = 6'h05;
    tick(); chk("bne_s1", {28'd0, state}, 1);
    tick(); chk("bne_s9", {28'd0, state}, 9);
    chk("bne_pc_we_z1", {31'd0, pc_we}, 0);
    zero = 1'b0; #1;
    chk("bne_pc_we_z0", {31'd0, pc_we}, 1);
    tick(); chk("bne_s0", {28'd0, state}, 0);
    chk("bne_ret", retired, 5);
    // JAL
    opcode = 6'h03;
    tick(); chk("jal_s1", {28'd0, state}, 1);
    tick(); chk("jal_s10", {28'd0, state}, 10);
    chk("jal_pc_we", {31'd0, pc_we}, 1);
    chk("jal_pc_src", {30'd0, pc_src}, 2);
    chk("jal_reg_we", {31'd0, reg_we}, 1);
    chk("jal_reg_dst", {30'd0, reg_dst}, 2);
    chk("jal_m2r", {30'd0, mem_to_reg}, 2);
    tick(); chk("jal_ret", retired, 6);
    // JR
    opcode = 6'h00; funct = 6'h08;
    tick(); chk("jr_s1", {28'd0, state}, 1);
    tick(); chk("jr_s10", {28'd0, state}, 10);
    chk("jr_pc_src", {30'd0, pc_src}, 3);
    chk("jr_reg_we", {31'd0, reg_we}, 0);
    tick(); chk("jr_ret", retired, 7);
    // XORI
    opcode = 6'h0E;
    tick(); chk("xori_s1", {28'd0, state}, 1);
    tick(); chk("xori_s3", {28'd0, state}, 3);
    chk("xori_alu_op", {29'd0, alu_op}, 2);
    chk("xori_src_b", {30'd0, alu_src_b}, 2);
    tick(); chk("xori_s8", {28'd0, state}, 8);
    chk("xori_reg_dst", {30'd0, reg_dst}, 0);
    tick(); chk("xori_ret", retired, 8);
    // Illegal opcode -> HALT, frozen for 10 cycles
    opcode = 6'h3F;
    tick(); chk("ill_s1", {28'd0, state}, 1);
    tick(); chk("ill_s11", {28'd0, state}, 11);
    chk("ill_halted", {31'd0, halted}, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_state", {28'd0, state}, 11);
      chk("halt_ret", retired, 8);
      chk("halt_pc_we", {31'd0, pc_we}, 0);
    end
    reset_n = 1'b0; #1;
    chk("halt_rst_halted", {31'd0, halted}, 0);
    tick(); reset_n = 1'b1; #1;
    chk("halt_rst_state", {28'd0, state}, 0);
    chk("halt_rst_ret", retired, 0);
    // Reset during MEM_RD abandons the load
    opcode = 6'h23;
    tick(); tick(); tick();
    chk("mid_s5", {28'd0, state}, 5);
    reset_n = 1'b0; #1;
    chk("mid_reg_we", {31'd0, reg_we}, 0);
    chk("mid_iord", {31'd0, iord}, 0);
    tick(); reset_n = 1'b1; #1;
    chk("mid_state", {28'd0, state}, 0);
    chk("mid_reg_we_after", {31'd0, reg_we}, 0);
    chk("mid_ret", retired, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
